// File: rtl/sample_capture.sv
// Triggered single-frame ADC capture buffer with optional decimation.
// Define CAPTURE_TRIG_EN for the level/edge trigger; without it capture free-runs from the first sample.
module sample_capture #(
  parameter int SAMPLES = 80,
  parameter int DECIM   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [11:0] trig_level,
  input  logic        trig_rising,
  input  logic        arm,
  input  logic        frame_ack,
  output logic [11:0] data [SAMPLES-1:0],
  output logic        frame_valid,
  output logic        busy
);

  localparam int IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IW-1:0] LAST  = IW'(SAMPLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_HOLD} state_t;

  state_t        r_st, w_nxt;
  logic [IW-1:0] r_widx, w_widx_nxt, w_waddr;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt;
  logic [11:0]   r_prev, w_prev_nxt;
  logic          r_pvld, w_pvld_nxt;
  logic          w_we, w_trig;
  logic          r_busy, r_fv;
  logic [11:0]   r_data [SAMPLES-1:0];

`ifdef CAPTURE_TRIG_EN
  always_comb begin
    w_trig = 1'b0;
    if (r_pvld)
      w_trig = trig_rising ? (r_prev < trig_level && adc_data >= trig_level)
                           : (r_prev > trig_level && adc_data <= trig_level);
  end
`else
  logic w_unused;
  assign w_trig   = 1'b1;
  assign w_unused = ^{trig_level, trig_rising, r_prev, r_pvld};
`endif

  always_comb begin
    w_nxt      = r_st;
    w_we       = 1'b0;
    w_waddr    = r_widx;
    w_widx_nxt = r_widx;
    w_dcnt_nxt = r_dcnt;
    w_prev_nxt = r_prev;
    w_pvld_nxt = r_pvld;
    case (r_st)
      S_IDLE: begin
        if (arm) begin
          w_nxt      = S_WAIT;
          w_pvld_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (adc_valid) begin
          w_prev_nxt = adc_data;
          w_pvld_nxt = 1'b1;
          if (w_trig) begin
            w_we       = 1'b1;
            w_waddr    = '0;
            w_dcnt_nxt = '0;
            if (LAST == '0) begin
              w_nxt      = S_HOLD;
              w_widx_nxt = '0;
            end else begin
              w_nxt      = S_CAPT;
              w_widx_nxt = IW'(1);
            end
          end
        end
      end
      S_CAPT: begin
        if (adc_valid) begin
          if (r_dcnt == DLAST) begin
            w_we       = 1'b1;
            w_dcnt_nxt = '0;
            // index saturates at the last entry; the frame is done
            if (r_widx == LAST) w_nxt = S_HOLD;
            else                w_widx_nxt = r_widx + IW'(1);
          end else begin
            w_dcnt_nxt = r_dcnt + DW'(1);
          end
        end
      end
      S_HOLD: begin
        if (frame_ack) begin
          w_nxt = arm ? S_WAIT : S_IDLE;
          if (arm) w_pvld_nxt = 1'b0;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_widx <= '0;
      r_dcnt <= '0;
      r_prev <= '0;
      r_pvld <= 1'b0;
      r_busy <= 1'b0;
      r_fv   <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_widx <= w_widx_nxt;
      r_dcnt <= w_dcnt_nxt;
      r_prev <= w_prev_nxt;
      r_pvld <= w_pvld_nxt;
      r_busy <= (w_nxt == S_WAIT) || (w_nxt == S_CAPT);
      r_fv   <= (w_nxt == S_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SAMPLES; i++) r_data[i] <= '0;
    end else if (w_we) begin
      r_data[w_waddr] <= adc_data;
    end
  end

  assign data        = r_data;
  assign frame_valid = r_fv;
  assign busy        = r_busy;

endmodule
